// File: rtl/blinky_pkg.sv
// Shared constants and types for the blinker / blink monitor pair.
`timescale 1ns/1ps
package blinky_pkg;

    localparam int unsigned CLK_FREQ_HZ   = 125_000_000;
    localparam int unsigned CYCLES_PER_US = CLK_FREQ_HZ / 1_000_000;

    typedef enum logic {
        IDLE,
        MEASURE
    } mon_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input plus
// registered-history edge detection.
`timescale 1ns/1ps
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], d_async};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~sync_d;
    assign fall  = ~level & sync_d;

endmodule

// File: rtl/blink_monitor.sv
// Measures period and high time of a slow periodic input in clk
// cycles and flags when rising edges stop arriving.
`timescale 1ns/1ps
module blink_monitor
    import blinky_pkg::*;
#(
    parameter int CLK_FREQ       = CLK_FREQ_HZ,
    parameter int CNT_WIDTH      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    output logic                 level,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 stuck
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic rise;
    logic fall;

    mon_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] high_lat_q, high_lat_d;
    logic [CNT_WIDTH-1:0] period_d, high_time_d;
    logic                 fall_seen_q, fall_seen_d;
    logic                 valid_d, stuck_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_async(sig_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_lat_q  <= '0;
            fall_seen_q <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_lat_q  <= high_lat_d;
            fall_seen_q <= fall_seen_d;
            period      <= period_d;
            high_time   <= high_time_d;
            valid       <= valid_d;
            stuck       <= stuck_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_lat_d  = high_lat_q;
        fall_seen_d = fall_seen_q;
        period_d    = period;
        high_time_d = high_time;
        valid_d     = 1'b0;
        stuck_d     = stuck;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d       = ONE;
                    fall_seen_d = 1'b0;
                    stuck_d     = 1'b0;
                    state_d     = MEASURE;
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + ONE;
                if (fall) begin
                    high_lat_d  = cnt_q;
                    fall_seen_d = 1'b1;
                end
                // A rise on the threshold cycle still completes the period
                if (rise) begin
                    cnt_d       = ONE;
                    fall_seen_d = 1'b0;
                    if (fall_seen_q) begin
                        period_d    = cnt_q;
                        high_time_d = high_lat_q;
                        valid_d     = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    stuck_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: two instances with different
// timeouts share one stimulus stream sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_blink_monitor;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;

    logic        a_level, a_valid, a_stuck;
    logic [31:0] a_period, a_high;
    logic        b_level, b_valid, b_stuck;
    logic [31:0] b_period, b_high;

    int checks = 0;
    int errors = 0;

    int ncyc = 0;
    int rise_at = 0;
    int valid_at = 0;
    int stuck_on_at = 0;
    int stuck_off_at = 0;
    int nvalid = 0;
    int nstuck = 0;
    int nvalid_b = 0;
    int nstuck_b = 0;
    logic stuck_prev = 1'b0;
    logic [31:0] exp_per = 1000;
    logic [31:0] exp_high = 100;

    always #4 clk = ~clk;

    blink_monitor #(
        .CNT_WIDTH     (32),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(5000)
    ) u_a (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .level    (a_level),
        .period   (a_period),
        .high_time(a_high),
        .valid    (a_valid),
        .stuck    (a_stuck)
    );

    blink_monitor #(
        .CNT_WIDTH     (32),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(1000)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .level    (b_level),
        .period   (b_period),
        .high_time(b_high),
        .valid    (b_valid),
        .stuck    (b_stuck)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d",
                   tag, obs, expv);
        end
    endtask

    task automatic step(input logic v);
        @(negedge clk);
        ncyc++;
        if (a_valid) begin
            nvalid++;
            valid_at = ncyc;
            chk("valid_period", a_period, exp_per);
            chk("valid_high", a_high, exp_high);
            chk("valid_latency", ncyc - rise_at, LAT);
            chk("valid_stuck", {31'd0, a_stuck}, 0);
        end
        if (a_stuck && !stuck_prev) stuck_on_at = ncyc;
        if (!a_stuck && stuck_prev) stuck_off_at = ncyc;
        stuck_prev = a_stuck;
        if (a_stuck) nstuck++;
        if (b_valid) begin
            nvalid_b++;
            chk("b_valid_period", b_period, 1000);
        end
        if (b_stuck) nstuck_b++;
        if (v && !sig_in) rise_at = ncyc;
        sig_in = v;
    endtask

    task automatic square(input int hi, input int per, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                step(i < hi);
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step(0);
        step(0);
        chk("rst_level", {31'd0, a_level}, 0);
        chk("rst_period", a_period, 0);
        chk("rst_high", a_high, 0);
        chk("rst_valid", {31'd0, a_valid}, 0);
        chk("rst_stuck", {31'd0, a_stuck}, 0);
        rst = 1'b0;
        step(0);

        // square wave 1000/100, 10 periods
        nvalid = 0;
        nstuck = 0;
        square(100, 1000, 1);
        chk("t1_first_rise", nvalid, 0);
        square(100, 1000, 9);
        chk("t1_valid_count", nvalid, 9);
        chk("t1_no_stuck", nstuck, 0);

        // timeout then recovery
        nvalid = 0;
        square(100, 1000, 2);
        chk("t3_valid_count", nvalid, 2);
        for (int i = 0; i < 4200; i++) step(0);
        chk("t3_stuck", {31'd0, a_stuck}, 1);
        chk("t3_stuck_delay", stuck_on_at - valid_at, 5000);
        chk("t3_keep_period", a_period, 1000);
        chk("t3_keep_high", a_high, 100);
        chk("t3_no_extra_valid", nvalid, 2);
        nvalid = 0;
        square(100, 1000, 1);
        chk("t3_clear_delay", stuck_off_at - rise_at, LAT);
        chk("t3_cleared", {31'd0, a_stuck}, 0);
        chk("t3_no_valid_first", nvalid, 0);
        square(100, 1000, 1);
        chk("t3_valid_second", nvalid, 1);

        // reset 500 cycles into a period
        for (int i = 0; i < 500; i++) step(i < 100);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        step(0);
        chk("t4_level", {31'd0, a_level}, 0);
        chk("t4_period", a_period, 0);
        chk("t4_high", a_high, 0);
        chk("t4_valid", {31'd0, a_valid}, 0);
        chk("t4_stuck", {31'd0, a_stuck}, 0);
        for (int i = 0; i < 498; i++) step(0);
        nvalid = 0;
        square(100, 1000, 1);
        chk("t4_no_valid", nvalid, 0);
        square(100, 1000, 1);
        chk("t4_valid", nvalid, 1);
        chk("t4_period_back", a_period, 1000);

        // duty sweep
        square(1, 1000, 1);
        exp_high = 1;
        square(1, 1000, 1);
        chk("t5_high_1", a_high, 1);
        square(2, 1000, 1);
        exp_high = 2;
        square(2, 1000, 1);
        chk("t5_high_2", a_high, 2);
        square(999, 1000, 1);
        exp_high = 999;
        square(999, 1000, 1);
        chk("t5_high_999", a_high, 999);
        chk("t5_period", a_period, 1000);

        // rise exactly at the 1000-cycle threshold
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        exp_high = 100;
        nvalid_b = 0;
        nstuck_b = 0;
        square(100, 1000, 5);
        chk("t6_valid_count", nvalid_b, 4);
        chk("t6_no_stuck", nstuck_b, 0);
        chk("t6_period", b_period, 1000);
        chk("t6_high", b_high, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
